// File: rtl/decode_pkg.sv
// Shared encodings for the RV32I/RV64I decode stage: opcodes, ALU ops,
// operand/PC selects and immediate formats.
package decode_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'h0,
      ALU_SLL  = 4'h1,
      ALU_SLT  = 4'h2,
      ALU_SLTU = 4'h3,
      ALU_XOR  = 4'h4,
      ALU_SRL  = 4'h5,
      ALU_OR   = 4'h6,
      ALU_AND  = 4'h7,
      ALU_SUB  = 4'h8,
      ALU_SRA  = 4'hD
   } alu_fn_e;

   typedef enum logic [1:0] {
      PC_PLUS4  = 2'd0,
      PC_BRANCH = 2'd1,
      PC_JAL    = 2'd2,
      PC_JALR   = 2'd3
   } pcsel_e;

   typedef enum logic [1:0] {
      A_RS1  = 2'd0,
      A_PC   = 2'd1,
      A_ZERO = 2'd2
   } asel_e;

   typedef enum logic [1:0] {
      B_RS2 = 2'd0,
      B_IMM = 2'd1
   } bsel_e;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_fmt_e;

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate extraction for the RISC-V I/S/B/U/J formats,
// sign-extended from instruction bit 31 to XLEN.
module imm_gen
   import decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:7]     instr,
   input  imm_fmt_e        fmt,
   output logic [XLEN-1:0] imm
);

   logic signed [31:0] imm32;

   always_comb begin
      imm32 = '0;
      case (fmt)
         IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   imm32 = {instr[31:12], 12'b0};
         IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   assign imm = XLEN'(imm32);

endmodule

// File: rtl/rv_decode_pipe.sv
// RV32I/RV64I decode stage: combinational decoder feeding an elastic,
// flushable output register with an optional one-entry skid buffer.
module rv_decode_pipe
   import decode_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int SKID_EN = 1
) (
   input  logic            clk,
   input  logic            nrst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [4:0]      rd,
   output logic [XLEN-1:0] imm,
   output logic [XLEN-1:0] pc,
   output logic [3:0]      alu_fn,
   output logic [1:0]      a_sel,
   output logic [1:0]      b_sel,
   output logic [1:0]      pcselect,
   output logic [2:0]      br_fn,
   output logic            we,
   output logic            btype,
   output logic            j,
   output logic            jr,
   output logic            is_load,
   output logic            is_store,
   output logic [2:0]      mem_size,
   output logic            illegal
);

   typedef struct packed {
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
      logic [3:0]      alu_fn;
      logic [1:0]      a_sel;
      logic [1:0]      b_sel;
      logic [1:0]      pcselect;
      logic [2:0]      br_fn;
      logic            we;
      logic            btype;
      logic            j;
      logic            jr;
      logic            is_load;
      logic            is_store;
      logic [2:0]      mem_size;
      logic            illegal;
   } decode_bundle_t;

   logic [6:0]      opc;
   logic [2:0]      f3;
   logic [6:0]      f7;
   imm_fmt_e        fmt;
   logic [XLEN-1:0] imm_p0;
   logic            legal;
   decode_bundle_t  dec_p0;

   assign opc = in_instr[6:0];
   assign f3  = in_instr[14:12];
   assign f7  = in_instr[31:25];

   // Stage p0: combinational decode of the offered instruction
   always_comb begin
      fmt = IMM_NONE;
      case (opc)
         OPC_LUI, OPC_AUIPC:            fmt = IMM_U;
         OPC_JAL:                       fmt = IMM_J;
         OPC_JALR, OPC_LOAD, OPC_OPIMM: fmt = IMM_I;
         OPC_BRANCH:                    fmt = IMM_B;
         OPC_STORE:                     fmt = IMM_S;
         default:                       fmt = IMM_NONE;
      endcase
   end

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr (in_instr[31:7]),
      .fmt   (fmt),
      .imm   (imm_p0)
   );

   always_comb begin
      dec_p0     = '0;
      dec_p0.pc  = in_pc;
      dec_p0.imm = imm_p0;
      legal      = 1'b1;
      case (opc)
         OPC_LUI: begin
            dec_p0.rd    = in_instr[11:7];
            dec_p0.a_sel = A_ZERO;
            dec_p0.b_sel = B_IMM;
            dec_p0.we    = 1'b1;
         end
         OPC_AUIPC: begin
            dec_p0.rd    = in_instr[11:7];
            dec_p0.a_sel = A_PC;
            dec_p0.b_sel = B_IMM;
            dec_p0.we    = 1'b1;
         end
         OPC_JAL: begin
            dec_p0.rd       = in_instr[11:7];
            dec_p0.a_sel    = A_PC;
            dec_p0.b_sel    = B_IMM;
            dec_p0.j        = 1'b1;
            dec_p0.pcselect = PC_JAL;
            dec_p0.we       = 1'b1;
         end
         OPC_JALR: begin
            dec_p0.rs1      = in_instr[19:15];
            dec_p0.rd       = in_instr[11:7];
            dec_p0.b_sel    = B_IMM;
            dec_p0.jr       = 1'b1;
            dec_p0.pcselect = PC_JALR;
            dec_p0.we       = 1'b1;
            legal           = (f3 == 3'b000);
         end
         OPC_BRANCH: begin
            dec_p0.rs1      = in_instr[19:15];
            dec_p0.rs2      = in_instr[24:20];
            dec_p0.btype    = 1'b1;
            dec_p0.br_fn    = f3;
            dec_p0.pcselect = PC_BRANCH;
            legal           = (f3[2:1] != 2'b01);
         end
         OPC_LOAD: begin
            dec_p0.rs1      = in_instr[19:15];
            dec_p0.rd       = in_instr[11:7];
            dec_p0.b_sel    = B_IMM;
            dec_p0.is_load  = 1'b1;
            dec_p0.we       = 1'b1;
            dec_p0.mem_size = f3;
            case (f3)
               3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
               3'b011, 3'b110:                         legal = (XLEN == 64);
               default:                                legal = 1'b0;
            endcase
         end
         OPC_STORE: begin
            dec_p0.rs1      = in_instr[19:15];
            dec_p0.rs2      = in_instr[24:20];
            dec_p0.b_sel    = B_IMM;
            dec_p0.is_store = 1'b1;
            dec_p0.mem_size = f3;
            legal           = !f3[2] && ((f3 != 3'b011) || (XLEN == 64));
         end
         OPC_OPIMM: begin
            dec_p0.rs1    = in_instr[19:15];
            dec_p0.rd     = in_instr[11:7];
            dec_p0.b_sel  = B_IMM;
            dec_p0.we     = 1'b1;
            dec_p0.alu_fn = {(f3 == 3'b101) ? in_instr[30] : 1'b0, f3};
            // RV64 shamt is 6 bits, so only instr[31:26] carries funct bits there
            if (f3 == 3'b001)
               legal = (XLEN == 64) ? (in_instr[31:26] == 6'b000000) : (f7 == 7'h00);
            else if (f3 == 3'b101)
               legal = (XLEN == 64) ? (in_instr[31:26] == 6'b000000 || in_instr[31:26] == 6'b010000)
                                    : (f7 == 7'h00 || f7 == 7'h20);
         end
         OPC_OP: begin
            dec_p0.rs1    = in_instr[19:15];
            dec_p0.rs2    = in_instr[24:20];
            dec_p0.rd     = in_instr[11:7];
            dec_p0.we     = 1'b1;
            dec_p0.alu_fn = {in_instr[30], f3};
            legal         = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
         end
         default: legal = 1'b0;
      endcase
      // Illegal words still travel so the trap can be raised in order
      if (!legal) begin
         dec_p0.we       = 1'b0;
         dec_p0.btype    = 1'b0;
         dec_p0.br_fn    = 3'b000;
         dec_p0.j        = 1'b0;
         dec_p0.jr       = 1'b0;
         dec_p0.is_load  = 1'b0;
         dec_p0.is_store = 1'b0;
         dec_p0.pcselect = PC_PLUS4;
      end
      if (dec_p0.rd == 5'd0)
         dec_p0.we = 1'b0;
      dec_p0.illegal = !legal;
   end

   decode_bundle_t main_p1;
   decode_bundle_t skid_p1;
   logic           vld_p1;
   logic           skid_vld_p1;
   logic           accept;
   logic           out_fire;

   assign in_ready = (SKID_EN != 0) ? !skid_vld_p1 : (!vld_p1 || out_ready);
   assign accept   = in_valid && in_ready && !flush;
   assign out_fire = vld_p1 && out_ready;

   // Stage p1: main output register plus skid entry
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         vld_p1      <= 1'b0;
         skid_vld_p1 <= 1'b0;
         main_p1     <= '0;
         skid_p1     <= '0;
      end else if (flush) begin
         vld_p1      <= 1'b0;
         skid_vld_p1 <= 1'b0;
      end else if (!vld_p1 || out_fire) begin
         if (skid_vld_p1) begin
            main_p1     <= skid_p1;
            vld_p1      <= 1'b1;
            skid_vld_p1 <= 1'b0;
         end else begin
            vld_p1 <= accept;
            if (accept)
               main_p1 <= dec_p0;
         end
      end else if (accept) begin
         skid_p1     <= dec_p0;
         skid_vld_p1 <= 1'b1;
      end
   end

   assign out_valid = vld_p1;
   assign rs1       = main_p1.rs1;
   assign rs2       = main_p1.rs2;
   assign rd        = main_p1.rd;
   assign imm       = main_p1.imm;
   assign pc        = main_p1.pc;
   assign alu_fn    = main_p1.alu_fn;
   assign a_sel     = main_p1.a_sel;
   assign b_sel     = main_p1.b_sel;
   assign pcselect  = main_p1.pcselect;
   assign br_fn     = main_p1.br_fn;
   assign we        = main_p1.we;
   assign btype     = main_p1.btype;
   assign j         = main_p1.j;
   assign jr        = main_p1.jr;
   assign is_load   = main_p1.is_load;
   assign is_store  = main_p1.is_store;
   assign mem_size  = main_p1.mem_size;
   assign illegal   = main_p1.illegal;

endmodule

// File: tb/tb_rv_decode_pipe.sv
// Directed bench for rv_decode_pipe: one XLEN=32 and one XLEN=64 instance
// driven by the same stimulus, both with the skid buffer enabled.
module tb_rv_decode_pipe;

   logic        clk = 1'b0;
   logic        nrst;
   logic        in_valid;
   logic        flush;
   logic        out_ready;
   logic [31:0] in_instr;
   logic [63:0] in_pc;

   logic        in_ready_32, out_valid_32, we_32, btype_32, j_32, jr_32, is_load_32, is_store_32, illegal_32;
   logic [4:0]  rs1_32, rs2_32, rd_32;
   logic [31:0] imm_32, pc_32;
   logic [3:0]  alu_fn_32;
   logic [1:0]  a_sel_32, b_sel_32, pcselect_32;
   logic [2:0]  br_fn_32, mem_size_32;

   logic        in_ready_64, out_valid_64, we_64, btype_64, j_64, jr_64, is_load_64, is_store_64, illegal_64;
   logic [4:0]  rs1_64, rs2_64, rd_64;
   logic [63:0] imm_64, pc_64;
   logic [3:0]  alu_fn_64;
   logic [1:0]  a_sel_64, b_sel_64, pcselect_64;
   logic [2:0]  br_fn_64, mem_size_64;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   rv_decode_pipe #(.XLEN(32), .SKID_EN(1)) u_dut32 (
      .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready_32),
      .in_instr(in_instr), .in_pc(in_pc[31:0]), .flush(flush),
      .out_valid(out_valid_32), .out_ready(out_ready),
      .rs1(rs1_32), .rs2(rs2_32), .rd(rd_32), .imm(imm_32), .pc(pc_32),
      .alu_fn(alu_fn_32), .a_sel(a_sel_32), .b_sel(b_sel_32), .pcselect(pcselect_32),
      .br_fn(br_fn_32), .we(we_32), .btype(btype_32), .j(j_32), .jr(jr_32),
      .is_load(is_load_32), .is_store(is_store_32), .mem_size(mem_size_32), .illegal(illegal_32)
   );

   rv_decode_pipe #(.XLEN(64), .SKID_EN(1)) u_dut64 (
      .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready_64),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
      .out_valid(out_valid_64), .out_ready(out_ready),
      .rs1(rs1_64), .rs2(rs2_64), .rd(rd_64), .imm(imm_64), .pc(pc_64),
      .alu_fn(alu_fn_64), .a_sel(a_sel_64), .b_sel(b_sel_64), .pcselect(pcselect_64),
      .br_fn(br_fn_64), .we(we_64), .btype(btype_64), .j(j_64), .jr(jr_64),
      .is_load(is_load_64), .is_store(is_store_64), .mem_size(mem_size_64), .illegal(illegal_64)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] instr, input logic [63:0] pcv);
      in_valid = 1'b1;
      in_instr = instr;
      in_pc    = pcv;
      step();
      in_valid = 1'b0;
   endtask

   typedef struct {
      logic [31:0] instr;
      logic        ill32;
      logic        we32;
      logic        ill64;
      logic        we64;
      logic [63:0] imm64;
      logic [1:0]  pcsel64;
      logic [4:0]  flags64;   // {btype, j, jr, is_load, is_store}
   } vec_t;

   vec_t vecs [10];

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{32'h800002B7, 1'b0, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_8000_0000, 2'd0, 5'b00000}; // lui x5
      vecs[1] = '{32'hFE20AC23, 1'b0, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 2'd0, 5'b00001}; // sw -8
      vecs[2] = '{32'h0100B183, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0000_0000_0000_0010, 2'd0, 5'b00010}; // ld
      vecs[3] = '{32'h00100013, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0000_0000_0000_0001, 2'd0, 5'b00000}; // addi x0
      vecs[4] = '{32'h008000EF, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0000_0000_0000_0008, 2'd2, 5'b01000}; // jal +8
      vecs[5] = '{32'h4020C1B3, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0000_0000_0000_0000, 2'd0, 5'b00000}; // xor f7=20
      vecs[6] = '{32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0000_0000_0000_0000, 2'd0, 5'b00000};
      vecs[7] = '{32'h02009093, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0000_0000_0000_0020, 2'd0, 5'b00000}; // slli 32
      vecs[8] = '{32'h000110E7, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0000_0000_0000_0000, 2'd0, 5'b00000}; // jalr f3=1
      vecs[9] = '{32'hFE000EE3, 1'b0, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 2'd1, 5'b10000}; // beq -4

      nrst      = 1'b0;
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      in_instr  = 32'h0;
      in_pc     = 64'h0;

      // reset state
      step();
      check("rst_out_valid", out_valid_64, 1'b0);
      check("rst_imm", imm_64, 64'h0);
      check("rst_pcselect", pcselect_64, 2'd0);
      check("rst_illegal", illegal_64, 1'b0);
      nrst = 1'b1;
      step();
      check("rst_in_ready", in_ready_64, 1'b1);

      // ADD then SUB back to back
      in_valid = 1'b1;
      in_instr = 32'h002081B3;
      in_pc    = 64'h100;
      step();
      in_instr = 32'h402081B3;
      in_pc    = 64'h104;
      check("add_valid", out_valid_64, 1'b1);
      check("add_alu", alu_fn_64, 4'h0);
      check("add_rd", rd_64, 5'd3);
      check("add_rs", {rs1_64, rs2_64}, {5'd1, 5'd2});
      check("add_we", we_64, 1'b1);
      check("add_pc", pc_64, 64'h100);
      step();
      in_valid = 1'b0;
      check("sub_valid", out_valid_64, 1'b1);
      check("sub_alu", alu_fn_64, 4'h8);
      check("sub_rd", rd_64, 5'd3);
      check("sub_pc", pc_64, 64'h104);
      check("sub_alu32", alu_fn_32, 4'h8);
      step();
      check("drain_valid", out_valid_64, 1'b0);

      // single-beat decode table across both widths
      for (int i = 0; i < 10; i++) begin
         issue(vecs[i].instr, 64'h200 + 64'(i * 4));
         check($sformatf("v%0d_valid", i), out_valid_64, 1'b1);
         check($sformatf("v%0d_ill64", i), illegal_64, vecs[i].ill64);
         check($sformatf("v%0d_we64", i), we_64, vecs[i].we64);
         check($sformatf("v%0d_imm64", i), imm_64, vecs[i].imm64);
         check($sformatf("v%0d_pcsel64", i), pcselect_64, vecs[i].pcsel64);
         check($sformatf("v%0d_flags64", i), {btype_64, j_64, jr_64, is_load_64, is_store_64}, vecs[i].flags64);
         check($sformatf("v%0d_ill32", i), illegal_32, vecs[i].ill32);
         check($sformatf("v%0d_we32", i), we_32, vecs[i].we32);
         check($sformatf("v%0d_imm32", i), imm_32, vecs[i].imm64[31:0]);
         if (i == 0)
            check("lui_sel", {a_sel_64, b_sel_64, alu_fn_64}, {2'd2, 2'd1, 4'h0});
         if (i == 1)
            check("sw_fields", {rd_64, mem_size_64, rs1_64, rs2_64}, {5'd0, 3'd2, 5'd1, 5'd2});
         if (i == 9)
            check("beq_fields", {rd_64, br_fn_64}, {5'd0, 3'd0});
      end
      step();

      // stall: continuous stream with out_ready low for three edges
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'h00100093;
      in_pc     = 64'h1000;
      step();
      check("stall_rdy1", in_ready_64, 1'b1);
      check("stall_pc1", pc_64, 64'h1000);
      in_instr = 32'h00200093;
      in_pc    = 64'h1004;
      step();
      check("stall_rdy2", in_ready_64, 1'b0);
      check("stall_pc2", pc_64, 64'h1000);
      in_instr = 32'h00300093;
      in_pc    = 64'h1008;
      step();
      check("stall_rdy3", in_ready_64, 1'b0);
      check("stall_hold_pc", pc_64, 64'h1000);
      check("stall_hold_imm", imm_64, 64'h1);
      out_ready = 1'b1;
      step();
      check("rel_valid1", out_valid_64, 1'b1);
      check("rel_pc1", pc_64, 64'h1004);
      check("rel_imm1", imm_64, 64'h2);
      check("rel_rdy", in_ready_64, 1'b1);
      step();
      in_valid = 1'b0;
      check("rel_pc2", pc_64, 64'h1008);
      check("rel_imm2", imm_32, 32'h3);
      step();
      check("rel_empty", out_valid_64, 1'b0);

      // flush with both entries full and a third word offered
      out_ready = 1'b0;
      issue(32'h00A00093, 64'h2000);
      issue(32'h00B00093, 64'h2004);
      check("fl_full_rdy", in_ready_64, 1'b0);
      in_valid = 1'b1;
      in_instr = 32'h00C00093;
      in_pc    = 64'h2008;
      flush    = 1'b1;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("fl_valid", out_valid_64, 1'b0);
      check("fl_rdy", in_ready_64, 1'b1);
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check($sformatf("fl_gone%0d", k), out_valid_64 | out_valid_32, 1'b0);
      end

      // input offered with in_ready=1 during flush is dropped
      in_valid = 1'b1;
      in_instr = 32'h00D00093;
      flush    = 1'b1;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("fl_drop", out_valid_64, 1'b0);

      // asynchronous reset mid-stream
      out_ready = 1'b0;
      issue(32'h800002B7, 64'h3000);
      check("mid_pre_valid", out_valid_64, 1'b1);
      #3;
      nrst = 1'b0;
      #1;
      check("mid_valid", out_valid_64, 1'b0);
      check("mid_imm", imm_64, 64'h0);
      check("mid_we", we_64, 1'b0);
      step();
      nrst = 1'b1;
      step();
      check("mid_rdy", in_ready_64, 1'b1);
      check("mid_valid_after", out_valid_32, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
